// File: rtl/audio_minmax_pkg.sv
// Shared types and helpers for the audio_minmax_stream envelope extractor:
// run-state enum, default widths and a saturating absolute value.
package audio_minmax_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FINISH
   } state_t;

   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 16;
   localparam int CNT_W_DEF  = 24;
   localparam int ABS_W      = 64;

   // |x| for a w-bit signed value carried sign-extended in ABS_W bits.
   // The most negative w-bit value clamps to the largest positive one.
   function automatic logic [ABS_W-1:0] sat_abs(input logic signed [ABS_W-1:0] x,
                                                input int w);
      logic [ABS_W-1:0] lim;
      logic [ABS_W-1:0] neg_lim;
      lim     = ABS_W'(1) << (w - 1);
      neg_lim = ~lim + ABS_W'(1);
      if (x == $signed(neg_lim)) begin
         sat_abs = lim - ABS_W'(1);
      end else if (x[ABS_W-1]) begin
         sat_abs = -x;
      end else begin
         sat_abs = x;
      end
   endfunction

endpackage

// File: rtl/audio_minmax_stream_lane.sv
// One channel of the envelope extractor: running min/max registers with a
// combinational view that already folds in the sample being accepted.
module minmax_lane
   import audio_minmax_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic              first,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] upd_min,
   output logic [DATA_W-1:0] upd_max
);

   logic [DATA_W-1:0] cur_min;
   logic [DATA_W-1:0] cur_max;

   // The first sample of an interval replaces history instead of comparing
   // against it, so stale values from the previous interval never leak in.
   always_comb begin
      upd_min = sample;
      upd_max = sample;
      if (!first) begin
         if ($signed(cur_min) < $signed(sample)) upd_min = cur_min;
         if ($signed(cur_max) > $signed(sample)) upd_max = cur_max;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_min <= '0;
         cur_max <= '0;
      end else if (load_en) begin
         cur_min <= upd_min;
         cur_max <= upd_max;
      end
   end

endmodule

// File: rtl/audio_minmax_stream.sv
// Streaming per-interval min/max envelope extractor for multi-channel audio.
// Optional m_peak output is enabled by defining AUDIO_MINMAX_PEAK_EN.
module audio_minmax_stream
   import audio_minmax_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int CHANNELS = 2,
   parameter int LEN_W    = LEN_W_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [LEN_W-1:0]           interval_len,
   input  logic [CNT_W-1:0]           num_samples,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [CHANNELS*DATA_W-1:0] s_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [CHANNELS*DATA_W-1:0] m_min,
   output logic [CHANNELS*DATA_W-1:0] m_max,
   output logic [CNT_W-1:0]           m_index,
   output logic                       m_last,
   output logic                       m_partial,
`ifdef AUDIO_MINMAX_PEAK_EN
   output logic [CHANNELS*DATA_W-1:0] m_peak,
`endif
   output logic                       busy,
   output logic                       done
);

   state_t state;
   state_t state_nxt;

   logic [LEN_W-1:0]           len_q;
   logic [LEN_W-1:0]           in_cnt;
   logic [CNT_W-1:0]           total_q;
   logic [CNT_W-1:0]           sample_cnt;
   logic [CNT_W-1:0]           int_idx;
   logic                       first;
   logic                       would_close;
   logic                       would_last;
   logic                       xfer;
   logic                       close_now;
   logic                       last_now;
   logic [CHANNELS*DATA_W-1:0] upd_min;
   logic [CHANNELS*DATA_W-1:0] upd_max;
`ifdef AUDIO_MINMAX_PEAK_EN
   logic [CHANNELS*DATA_W-1:0] upd_peak;
`endif

   // Whether the next accepted sample ends an interval depends only on the
   // counters, so input flow control never waits on the sample data.
   assign first       = (in_cnt == '0);
   assign would_last  = (sample_cnt == total_q - CNT_W'(1));
   assign would_close = (in_cnt == len_q - LEN_W'(1)) || would_last;
   assign xfer        = s_valid && s_ready;
   assign close_now   = xfer && would_close;
   assign last_now    = xfer && would_last;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      minmax_lane #(
         .DATA_W (DATA_W)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .load_en (xfer),
         .first   (first),
         .sample  (s_data[c*DATA_W +: DATA_W]),
         .upd_min (upd_min[c*DATA_W +: DATA_W]),
         .upd_max (upd_max[c*DATA_W +: DATA_W])
      );
`ifdef AUDIO_MINMAX_PEAK_EN
      logic [DATA_W-1:0] abs_min;
      logic [DATA_W-1:0] abs_max;
      assign abs_min = DATA_W'(sat_abs(ABS_W'($signed(upd_min[c*DATA_W +: DATA_W])), DATA_W));
      assign abs_max = DATA_W'(sat_abs(ABS_W'($signed(upd_max[c*DATA_W +: DATA_W])), DATA_W));
      assign upd_peak[c*DATA_W +: DATA_W] = (abs_min > abs_max) ? abs_min : abs_max;
`endif
   end

   // Run state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and status outputs; input stalls only when an interval
   // would close while the previous record is still waiting downstream.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (num_samples == '0) ? FINISH : RUN;
         end
         RUN: begin
            busy    = 1'b1;
            s_ready = !(m_valid && !m_ready && would_close);
            if (last_now) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (m_valid && m_ready) state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Run parameters are captured once at start so mid-run input changes
   // cannot disturb interval boundaries.
   always_ff @(posedge clk) begin
      if (reset) begin
         len_q      <= '0;
         total_q    <= '0;
         sample_cnt <= '0;
         in_cnt     <= '0;
         int_idx    <= '0;
      end else if (state == IDLE && start) begin
         len_q      <= (interval_len == '0) ? LEN_W'(1) : interval_len;
         total_q    <= num_samples;
         sample_cnt <= '0;
         in_cnt     <= '0;
         int_idx    <= '0;
      end else if (xfer) begin
         sample_cnt <= sample_cnt + CNT_W'(1);
         if (would_close) begin
            in_cnt  <= '0;
            int_idx <= int_idx + CNT_W'(1);
         end else begin
            in_cnt  <= in_cnt + LEN_W'(1);
         end
      end
   end

   // Output record register; a close in the same cycle as a handshake
   // reloads it so m_valid stays high without a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid   <= 1'b0;
         m_min     <= '0;
         m_max     <= '0;
         m_index   <= '0;
         m_last    <= 1'b0;
         m_partial <= 1'b0;
`ifdef AUDIO_MINMAX_PEAK_EN
         m_peak    <= '0;
`endif
      end else if (close_now) begin
         m_valid   <= 1'b1;
         m_min     <= upd_min;
         m_max     <= upd_max;
         m_index   <= int_idx;
         m_last    <= would_last;
         m_partial <= would_last && (in_cnt != len_q - LEN_W'(1));
`ifdef AUDIO_MINMAX_PEAK_EN
         m_peak    <= upd_peak;
`endif
      end else if (m_valid && m_ready) begin
         m_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_minmax_stream.sv
// Directed bench for audio_minmax_stream: a chunk-based reference model
// builds the expected record list, and a monitor checks every handshake.
module tb_audio_minmax_stream;

   localparam int DATA_W   = 32;
   localparam int CHANNELS = 2;
   localparam int LEN_W    = 16;
   localparam int CNT_W    = 24;

   typedef struct packed {
      logic [63:0] mn;
      logic [63:0] mx;
      logic [63:0] pk;
      logic [23:0] idx;
      logic        last;
      logic        partial;
   } rec_t;

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic                       start = 1'b0;
   logic [LEN_W-1:0]           interval_len = '0;
   logic [CNT_W-1:0]           num_samples = '0;
   logic                       s_valid = 1'b0;
   logic                       s_ready;
   logic [CHANNELS*DATA_W-1:0] s_data = '0;
   logic                       m_valid;
   logic                       m_ready = 1'b1;
   logic [CHANNELS*DATA_W-1:0] m_min;
   logic [CHANNELS*DATA_W-1:0] m_max;
   logic [CNT_W-1:0]           m_index;
   logic                       m_last;
   logic                       m_partial;
`ifdef AUDIO_MINMAX_PEAK_EN
   logic [CHANNELS*DATA_W-1:0] m_peak;
`endif
   logic                       busy;
   logic                       done;

   rec_t        exp_q[$];
   logic [63:0] stim_q[$];
   rec_t        mon_rec;
   int          compared = 0;
   int          mismatched = 0;
   int          acc_cnt = 0;
   int          done_cnt = 0;
   int          last_cycles = 0;
   logic        drv_done = 1'b0;

   audio_minmax_stream #(
      .DATA_W   (DATA_W),
      .CHANNELS (CHANNELS),
      .LEN_W    (LEN_W),
      .CNT_W    (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .interval_len (interval_len),
      .num_samples  (num_samples),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_min        (m_min),
      .m_max        (m_max),
      .m_index      (m_index),
      .m_last       (m_last),
      .m_partial    (m_partial),
`ifdef AUDIO_MINMAX_PEAK_EN
      .m_peak       (m_peak),
`endif
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [63:0] pack2(input int ch0, input int ch1);
      logic [31:0] a;
      logic [31:0] b;
      a = ch0;
      b = ch1;
      return {b, a};
   endfunction

   // Reference: split the sample list into chunks of max(len,1) and take
   // plain min/max over each chunk; the final chunk may be short.
   function automatic void buildExpected(input int len, input int num);
      int                 eff;
      int                 n;
      int                 k;
      logic [63:0]        w;
      logic signed [31:0] v;
      logic signed [31:0] mn;
      logic signed [31:0] mx;
      longint             a;
      longint             b;
      rec_t               r;
      eff = (len == 0) ? 1 : len;
      k = 0;
      for (int base = 0; base < num; base += eff) begin
         n = (num - base < eff) ? (num - base) : eff;
         r = '0;
         for (int c = 0; c < CHANNELS; c++) begin
            w  = stim_q[base];
            mn = $signed(w[c*32 +: 32]);
            mx = mn;
            for (int j = base; j < base + n; j++) begin
               w = stim_q[j];
               v = $signed(w[c*32 +: 32]);
               if (v < mn) mn = v;
               if (v > mx) mx = v;
            end
            a = mn;
            b = mx;
            if (a < 0) a = -a;
            if (b < 0) b = -b;
            if (a > 64'sd2147483647) a = 64'sd2147483647;
            if (b > 64'sd2147483647) b = 64'sd2147483647;
            r.mn[c*32 +: 32] = mn;
            r.mx[c*32 +: 32] = mx;
            r.pk[c*32 +: 32] = (a > b) ? 32'(a) : 32'(b);
         end
         r.idx     = 24'(k);
         r.last    = (base + n >= num);
         r.partial = r.last && (n < eff);
         exp_q.push_back(r);
         k++;
      end
   endfunction

   // Monitor: every output handshake must match the next expected record.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (done) done_cnt++;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL extra_record: got index %0d, expected none", m_index);
            end else begin
               mon_rec = exp_q.pop_front();
               checkOutput("m_min", m_min, mon_rec.mn);
               checkOutput("m_max", m_max, mon_rec.mx);
               checkOutput("m_index", 64'(m_index), 64'(mon_rec.idx));
               checkOutput("m_last", 64'(m_last), 64'(mon_rec.last));
               checkOutput("m_partial", 64'(m_partial), 64'(mon_rec.partial));
`ifdef AUDIO_MINMAX_PEAK_EN
               checkOutput("m_peak", m_peak, mon_rec.pk);
`endif
            end
         end
      end
   end

   task automatic startRun(input int len, input int num);
      @(negedge clk);
      interval_len = LEN_W'(len);
      num_samples  = CNT_W'(num);
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      interval_len = LEN_W'(1);
      num_samples  = CNT_W'(1);
   endtask

   // Presents stim_q in order, holding each sample until it is accepted.
   task automatic applyStimulus(input int max_cycles);
      int i;
      int cyc;
      i   = 0;
      cyc = 0;
      while (i < stim_q.size() && cyc < max_cycles) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = stim_q[i];
         #4;
         if (s_ready) begin
            i++;
            acc_cnt++;
         end
         cyc++;
         @(posedge clk);
      end
      last_cycles = cyc;
      if (i < stim_q.size()) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL input_timeout: got %0d accepted, expected %0d", i, stim_q.size());
      end
   endtask

   task automatic waitRunEnd(input int d0, input string tag);
      int cyc;
      cyc = 0;
      @(negedge clk);
      s_valid = 1'b0;
      while (done_cnt == d0 && cyc < 100) begin
         @(negedge clk);
         #5;
         cyc++;
      end
      repeat (3) @(negedge clk);
      #5;
      checkOutput({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
      checkOutput({tag, "_records_left"}, 64'(exp_q.size()), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      mismatched++;
      $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      rec_t t;
      int   d0;
      int   a0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #4;
      checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
      checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_m_min", m_min, 64'd0);
      checkOutput("rst_m_index", 64'(m_index), 64'd0);

      // Two full intervals of four.
      $display("[TB] len=4 num=8");
      stim_q = {pack2(5, 100), pack2(-3, -200), pack2(7, 50), pack2(0, 0),
                pack2(1, -1), pack2(2, 300), pack2(-9, 7), pack2(4, -8)};
      buildExpected(4, 8);
      checkOutput("pin1_count", 64'(exp_q.size()), 64'd2);
      t = exp_q[0];
      checkOutput("pin1_r0_min", 64'(t.mn[31:0]), 64'h0000_0000_FFFF_FFFD);
      checkOutput("pin1_r0_max", 64'(t.mx[31:0]), 64'd7);
      checkOutput("pin1_r0_ch1_min", 64'(t.mn[63:32]), 64'h0000_0000_FFFF_FF38);
      t = exp_q[1];
      checkOutput("pin1_r1_min", 64'(t.mn[31:0]), 64'h0000_0000_FFFF_FFF7);
      checkOutput("pin1_r1_max", 64'(t.mx[31:0]), 64'd4);
      checkOutput("pin1_r1_flags", {62'd0, t.last, t.partial}, 64'd2);
      d0 = done_cnt;
      startRun(4, 8);
      applyStimulus(50);
      #1;
      checkOutput("latency_m_valid", 64'(m_valid), 64'd1);
      checkOutput("latency_m_last", 64'(m_last), 64'd1);
      waitRunEnd(d0, "run1");

      // Partial final interval.
      $display("[TB] len=4 num=6");
      stim_q = {pack2(3, -1), pack2(1, -2), pack2(4, -3), pack2(1, -4),
                pack2(5, -5), pack2(9, -6)};
      buildExpected(4, 6);
      checkOutput("pin2_count", 64'(exp_q.size()), 64'd2);
      t = exp_q[1];
      checkOutput("pin2_r1_partial", 64'(t.partial), 64'd1);
      checkOutput("pin2_r1_min", 64'(t.mn[31:0]), 64'd5);
      d0 = done_cnt;
      startRun(4, 6);
      applyStimulus(50);
      waitRunEnd(d0, "run2");

      // Zero length acts as one; one sample per cycle, no stall.
      $display("[TB] len=0 num=3");
      stim_q = {pack2(10, -10), pack2(20, -20), pack2(30, -30)};
      buildExpected(0, 3);
      checkOutput("pin3_count", 64'(exp_q.size()), 64'd3);
      t = exp_q[2];
      checkOutput("pin3_r2_minmax", {t.mn[31:0], t.mx[31:0]}, {32'd30, 32'd30});
      d0 = done_cnt;
      startRun(0, 3);
      applyStimulus(50);
      checkOutput("len0_cycles", 64'(last_cycles), 64'd3);
      waitRunEnd(d0, "run3");

      // Downstream held off for ten cycles with two-sample intervals.
      $display("[TB] len=2 num=6 backpressure");
      stim_q = {pack2(1, 2), pack2(-1, -2), pack2(8, 0), pack2(6, 1),
                pack2(-4, 9), pack2(3, -9)};
      buildExpected(2, 6);
      m_ready = 1'b0;
      d0 = done_cnt;
      a0 = acc_cnt;
      startRun(2, 6);
      fork
         applyStimulus(100);
         begin
            repeat (9) @(negedge clk);
            #4;
            checkOutput("stall_accepted", 64'(acc_cnt - a0), 64'd3);
            checkOutput("stall_s_ready", 64'(s_ready), 64'd0);
            checkOutput("stall_m_index", 64'(m_index), 64'd0);
            @(negedge clk);
            m_ready = 1'b1;
         end
      join
      waitRunEnd(d0, "run4");

      // Extreme values under random downstream readiness.
      $display("[TB] len=3 num=10 random ready");
      stim_q = {pack2(32'h8000_0000, 32'h7FFF_FFFF), pack2(0, 1), pack2(-1, 32'h8000_0000),
                pack2(32'h7FFF_FFFF, 5), pack2(6, 6), pack2(-6, -6), pack2(100, -100),
                pack2(2, 3), pack2(-2, -3), pack2(77, 88)};
      buildExpected(3, 10);
      d0 = done_cnt;
      drv_done = 1'b0;
      startRun(3, 10);
      fork
         begin
            applyStimulus(300);
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(negedge clk);
               m_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            m_ready = 1'b1;
         end
      join
      waitRunEnd(d0, "run5");

`ifdef AUDIO_MINMAX_PEAK_EN
      // Most negative sample saturates the peak magnitude.
      $display("[TB] peak saturation");
      stim_q = {pack2(1, 32'h8000_0000), pack2(-1, 5)};
      buildExpected(2, 2);
      t = exp_q[0];
      checkOutput("pin_peak_ch1", 64'(t.pk[63:32]), 64'h0000_0000_7FFF_FFFF);
      d0 = done_cnt;
      startRun(2, 2);
      applyStimulus(50);
      waitRunEnd(d0, "peak");
`endif

      // Abort mid-interval, then an empty run.
      $display("[TB] reset mid-run");
      stim_q = {pack2(11, 12), pack2(13, 14)};
      startRun(4, 8);
      applyStimulus(50);
      @(negedge clk);
      s_valid = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      #4;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_s_ready", 64'(s_ready), 64'd0);
      checkOutput("abort_m_valid", 64'(m_valid), 64'd0);
      checkOutput("abort_m_max", m_max, 64'd0);
      checkOutput("abort_flags", {62'd0, m_last, m_partial}, 64'd0);
      startRun(4, 0);
      #4;
      checkOutput("num0_done", 64'(done), 64'd1);
      checkOutput("num0_m_valid", 64'(m_valid), 64'd0);
      checkOutput("num0_busy", 64'(busy), 64'd0);
      @(negedge clk);
      #4;
      checkOutput("num0_done_clear", 64'(done), 64'd0);
      checkOutput("num0_records_left", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
